core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl_pkg.sv | 35 +++
 rtl/core_ctrl_delay_line.sv | 30 +++
 rtl/core_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_core_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for core_ctrl: instruction field positions, the idle word and the FSM state type.
package core_ctrl_pkg;

    localparam int INST_W       = 35;
    localparam int ADDR_W       = 11;

    localparam int ACC_BIT      = 34;
    localparam int CEN_PMEM_BIT = 33;
    localparam int WEN_PMEM_BIT = 32;
    localparam int A_PMEM_LSB   = 21;
    localparam int CEN_XMEM_BIT = 20;
    localparam int WEN_XMEM_BIT = 19;
    localparam int A_XMEM_LSB   = 8;
    localparam int OFIFO_RD_BIT = 7;
    localparam int IFIFO_WR_BIT = 6;
    localparam int IFIFO_RD_BIT = 5;
    localparam int L0_RD_BIT    = 4;
    localparam int L0_WR_BIT    = 3;
    localparam int EXECUTE_BIT  = 2;
    localparam int LOAD_BIT     = 1;

    // Memory enables are active-low, so the quiet word holds both CEN/WEN pairs high.
    localparam logic [INST_W-1:0] IDLE_WORD = 35'h3_0018_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_KLOAD  = 3'd2,
        S_KFLUSH = 3'd3,
        S_EXEC   = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/core_ctrl_delay_line.sv
// ctrl_delay_line: fixed-depth shift register used to align L0 strobes with SRAM read latency.
module ctrl_delay_line
    import core_ctrl_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q;

    // Shift one stage per cycle; reset flushes any in-flight strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= {(DEPTH*WIDTH){1'b0}};
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sr_q[i] <= sr_q[i-1];
            end
            sr_q[0] <= d;
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: sequences weight load, kernel load, execute and output drain into a registered instruction word.
// Optional feature: define CORE_CTRL_PERF_EN to add the 32-bit cycle_cnt busy-cycle counter port.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int row        = 8,
    parameter int col        = 8,
    parameter int inst_width = 35,
    parameter int addr_bw    = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_bw-1:0]    w_base,
    input  logic [addr_bw-1:0]    a_base,
    input  logic [addr_bw-1:0]    p_base,
    input  logic [addr_bw-1:0]    num_act,
    input  logic                  ofifo_valid,
    output logic [inst_width-1:0] inst,
    output logic                  busy,
    output logic                  done
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [31:0]           cycle_cnt
`endif
);

    localparam int CW = addr_bw + 1;

    state_e                st_q;
    logic [CW-1:0]         cnt_q;
    logic [addr_bw-1:0]    w_base_q, a_base_q, p_base_q, num_act_q, out_cnt_q;
    logic                  busy_q, done_q;
    logic [inst_width-1:0] inst_q, inst_d;

    logic                  wrd_s, ard_s, klod_s, drain_s;
    logic                  l0wr_dly_s, exe_dly_s;
    logic [addr_bw-1:0]    xaddr_s;

    // Strobes issued in the current state; the instruction register adds one cycle on top.
    always_comb begin
        wrd_s   = (st_q == S_LOAD_W) && (cnt_q < CW'(row));
        ard_s   = (st_q == S_EXEC) && (cnt_q < {1'b0, num_act_q});
        klod_s  = (st_q == S_KLOAD);
        drain_s = ((st_q == S_EXEC) || (st_q == S_DRAIN)) && ofifo_valid
                  && (out_cnt_q != num_act_q);
        xaddr_s = (wrd_s ? w_base_q : a_base_q) + cnt_q[addr_bw-1:0];
    end

    ctrl_delay_line #(.WIDTH(1), .DEPTH(1)) u_dly_l0wr (
        .clk   (clk),
        .reset (reset),
        .d     (wrd_s | ard_s),
        .q     (l0wr_dly_s)
    );

    ctrl_delay_line #(.WIDTH(1), .DEPTH(2)) u_dly_exec (
        .clk   (clk),
        .reset (reset),
        .d     (ard_s),
        .q     (exe_dly_s)
    );

    // Assemble the next instruction word from all concurrently active fields.
    always_comb begin
        inst_d                              = inst_width'(IDLE_WORD);
        inst_d[CEN_XMEM_BIT]                = ~(wrd_s | ard_s);
        inst_d[A_XMEM_LSB +: addr_bw]       = (wrd_s | ard_s) ? xaddr_s : {addr_bw{1'b0}};
        inst_d[CEN_PMEM_BIT]                = ~drain_s;
        inst_d[WEN_PMEM_BIT]                = ~drain_s;
        inst_d[A_PMEM_LSB +: addr_bw]       = drain_s ? (p_base_q + out_cnt_q) : {addr_bw{1'b0}};
        inst_d[OFIFO_RD_BIT]                = drain_s;
        inst_d[L0_WR_BIT]                   = l0wr_dly_s;
        inst_d[L0_RD_BIT]                   = klod_s | exe_dly_s;
        inst_d[EXECUTE_BIT]                 = exe_dly_s;
        inst_d[LOAD_BIT]                    = klod_s;
    end

    // Control FSM with registered instruction, busy and done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            out_cnt_q <= {addr_bw{1'b0}};
            w_base_q  <= {addr_bw{1'b0}};
            a_base_q  <= {addr_bw{1'b0}};
            p_base_q  <= {addr_bw{1'b0}};
            num_act_q <= {addr_bw{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            inst_q    <= inst_width'(IDLE_WORD);
        end else begin
            inst_q <= inst_d;
            cnt_q  <= cnt_q + CW'(1);
            done_q <= 1'b0;
            if (drain_s) begin
                out_cnt_q <= out_cnt_q + addr_bw'(1);
            end else begin
                out_cnt_q <= out_cnt_q;
            end
            case (st_q)
                S_IDLE: begin
                    cnt_q     <= {CW{1'b0}};
                    out_cnt_q <= {addr_bw{1'b0}};
                    if (start) begin
                        w_base_q  <= w_base;
                        a_base_q  <= a_base;
                        p_base_q  <= p_base;
                        num_act_q <= num_act;
                        busy_q    <= 1'b1;
                        if (num_act != {addr_bw{1'b0}}) begin
                            st_q <= S_LOAD_W;
                        end else begin
                            st_q   <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_LOAD_W: begin
                    if (cnt_q == CW'(row)) begin
                        st_q  <= S_KLOAD;
                        cnt_q <= {CW{1'b0}};
                    end
                end
                S_KLOAD: begin
                    if (cnt_q == CW'(col - 1)) begin
                        st_q  <= S_KFLUSH;
                        cnt_q <= {CW{1'b0}};
                    end
                end
                S_KFLUSH: begin
                    if (cnt_q == CW'(row - 1)) begin
                        st_q  <= S_EXEC;
                        cnt_q <= {CW{1'b0}};
                    end
                end
                S_EXEC: begin
                    if (cnt_q == ({1'b0, num_act_q} + CW'(1))) begin
                        st_q  <= S_DRAIN;
                        cnt_q <= {CW{1'b0}};
                    end
                end
                S_DRAIN: begin
                    if (out_cnt_q == num_act_q) begin
                        st_q   <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    st_q   <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    st_q   <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef CORE_CTRL_PERF_EN
    logic [31:0] cyc_q;

    // Busy-cycle counter: cleared on an accepted start, frozen once busy drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= 32'd0;
        end else if ((st_q == S_IDLE) && start) begin
            cyc_q <= 32'd0;
        end else if (busy_q) begin
            cyc_q <= cyc_q + 32'd1;
        end else begin
            cyc_q <= cyc_q;
        end
    end

    assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: expected instruction events are queued with cycle stamps and popped by a monitor.
module tb_core_ctrl;

    localparam logic [34:0] IDLE_W = 35'h3_0018_0000;

    typedef struct {
        int          cyc;
        logic [34:0] word;
        logic        dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] w_base, a_base, p_base, num_act;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        busy, done;
`ifdef CORE_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    core_ctrl #(.row(8), .col(8), .inst_width(35), .addr_bw(11)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .w_base      (w_base),
        .a_base      (a_base),
        .p_base      (p_base),
        .num_act     (num_act),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
`ifdef CORE_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected word built from the documented field map.
    function automatic logic [34:0] mkw(input bit xr, input logic [10:0] xa,
                                        input bit pw, input logic [10:0] pa,
                                        input bit l0wr, input bit l0rd,
                                        input bit exe, input bit load);
        logic [34:0] r;
        r = IDLE_W;
        if (xr) begin
            r[20]   = 1'b0;
            r[18:8] = xa;
        end
        if (pw) begin
            r[33]    = 1'b0;
            r[32]    = 1'b0;
            r[31:21] = pa;
            r[7]     = 1'b1;
        end
        r[3] = l0wr;
        r[4] = l0rd;
        r[2] = exe;
        r[1] = load;
        return r;
    endfunction

    task automatic push(input int stamp, input logic [34:0] word, input logic dn);
        exp_t e;
        e.cyc  = stamp;
        e.word = word;
        e.dn   = dn;
        exp_q.push_back(e);
    endtask

    // Weight reads, lagging L0_WR, then kernel load; events k are seen after edge k.
    task automatic push_load(input int base, input logic [10:0] wb);
        for (int k = 1; k <= 9; k++) begin
            push(base + 1 + k, mkw(k <= 8, wb + 11'(k - 1), 1'b0, 11'h000,
                                   k >= 2, 1'b0, 1'b0, 1'b0), 1'b0);
        end
        for (int k = 10; k <= 17; k++) begin
            push(base + 1 + k, mkw(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
        end
    endtask

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every non-idle word or done pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (inst !== IDLE_W || done !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: cyc=%0d inst=%h done=%b, none expected", cyc, inst, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.word !== inst || e.dn !== done) begin
                        errors++;
                        $display("FAIL inst_event: got cyc=%0d inst=%h done=%b expected cyc=%0d inst=%h done=%b",
                                 cyc, inst, done, e.cyc, e.word, e.dn);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
        w_base = 11'h000; a_base = 11'h000; p_base = 11'h000; num_act = 11'h000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_inst", inst, IDLE_W);
        chk("reset_busy", {34'd0, busy}, 35'd0);
        chk("reset_done", {34'd0, done}, 35'd0);

        // Full tile: weights at 0x100, 4 activations at 0x010, outputs to 0x020.
        base = cyc;
        start = 1'b1; w_base = 11'h100; a_base = 11'h010; p_base = 11'h020; num_act = 11'd4;
        push_load(base, 11'h100);
        push(base + 27, mkw(1'b1, 11'h010, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        push(base + 28, mkw(1'b1, 11'h011, 1'b1, 11'h020, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        push(base + 29, mkw(1'b1, 11'h012, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
        push(base + 30, mkw(1'b1, 11'h013, 1'b1, 11'h021, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
        push(base + 31, mkw(1'b0, 11'h000, 1'b1, 11'h022, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
        push(base + 32, mkw(1'b0, 11'h000, 1'b1, 11'h023, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0);
        push(base + 33, IDLE_W, 1'b1);
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            start = (k == 12);
            if (k == 12) num_act = 11'd0;
            ofifo_valid = (k == 26) || (k == 28) || (k == 29) || (k == 30) || (k == 31);
            if (k == 0)  chk("busy_after_start", {34'd0, busy}, 35'd1);
            if (k == 32) chk("busy_at_done", {34'd0, busy}, 35'd1);
            if (k == 33) chk("busy_after_done", {34'd0, busy}, 35'd0);
`ifdef CORE_CTRL_PERF_EN
            if (k == 34) chk("cycle_cnt", {3'd0, cycle_cnt}, 35'd33);
`endif
        end
        ofifo_valid = 1'b0;

        // Degenerate start: immediate done, one busy cycle, no instruction fields.
        base = cyc;
        start = 1'b1; num_act = 11'd0;
        push(base + 1, IDLE_W, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("degen_busy_high", {34'd0, busy}, 35'd1);
        @(negedge clk);
        chk("degen_busy_low", {34'd0, busy}, 35'd0);
        repeat (2) @(negedge clk);

        // Address wrap on activation reads, then reset mid-EXEC.
        base = cyc;
        start = 1'b1; w_base = 11'h000; a_base = 11'h7FE; p_base = 11'h000; num_act = 11'd3;
        push_load(base, 11'h000);
        push(base + 27, mkw(1'b1, 11'h7FE, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        push(base + 28, mkw(1'b1, 11'h7FF, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        push(base + 29, mkw(1'b1, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
        for (int k = 0; k <= 28; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 28) reset = 1'b1;
        end
        @(negedge clk);
        chk("abort_inst", inst, IDLE_W);
        chk("abort_busy", {34'd0, busy}, 35'd0);
        chk("abort_done", {34'd0, done}, 35'd0);
        reset = 1'b0;
        ofifo_valid = 1'b1;
        repeat (5) @(negedge clk);
        ofifo_valid = 1'b0;
        @(negedge clk);
        chk("scoreboard_empty", 35'(exp_q.size()), 35'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
